// File: rtl/sti_serializer_p_if.sv
//==============================================================================
// Module   : sti_serializer_p_if
// Brief    : Load-side and serial-side signal bundle of the STI serializer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface sti_serializer_p_if #(
    parameter int DATA_W = 16
);
    logic              load;
    logic [DATA_W-1:0] pi_data;
    logic [1:0]        pi_length;
    logic              pi_fill;
    logic              pi_msb;
    logic              pi_low;
    logic              pi_end;
    logic              pi_ready;
    logic              so_data;
    logic              so_valid;
    logic              so_last;
    logic              done;
    logic              ovf_err;

    modport slave (
        input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        output pi_ready, so_data, so_valid, so_last, done, ovf_err
    );

    modport master (
        output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        input  pi_ready, so_data, so_valid, so_last, done, ovf_err
    );
endinterface

`default_nettype wire

// File: rtl/sti_serializer_p.sv
//==============================================================================
// Module   : sti_serializer_p
// Brief    : FIFO-buffered parallel-to-serial STI frame transmitter.
// Options  : define STI_PARITY_EN to append an even-parity bit to every frame
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sti_serializer_p #(
    parameter int DATA_W     = 16,
    parameter int UNIT       = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    sti_serializer_p_if.slave  bus
);
    localparam int             c_FW      = 4 * UNIT;
    localparam int             c_PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int             c_CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [5:0]     c_DW6     = 6'(DATA_W);
    localparam logic [5:0]     c_FW6     = 6'(c_FW);
    localparam logic [c_PW-1:0] c_PTR_MAX = c_PW'(FIFO_DEPTH - 1);
    localparam logic [c_CW-1:0] c_DEPTH  = c_CW'(FIFO_DEPTH);
    localparam logic [c_FW-1:0] c_ONES   = '1;
    localparam logic [c_FW-1:0] c_ONE    = {{(c_FW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Control word layout: {end, msb, low, fill, length[1:0]}
    logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [5:0]        r_mem_ctl  [FIFO_DEPTH];
    logic [c_PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic              r_end_seen, r_ready;

    state_t            r_state, w_state_nxt;
    logic [c_FW-1:0]   r_frame;
    logic [5:0]        r_flen, r_cnt;
    logic              r_msb, r_cur_end;
    logic              r_so_data, r_so_valid, r_so_last;
    logic              r_done_pend, r_done, r_ovf;

    logic              w_accept, w_pop, w_shift, w_last, w_nonempty, w_bit, w_bit_frame;
    logic [DATA_W-1:0] w_head_data;
    logic [5:0]        w_head_ctl, w_flen, w_idx, w_final_cnt;
    logic [c_FW-1:0]   w_ext, w_frame;
    logic [c_CW-1:0]   w_count_nxt;
    logic              w_end_seen_nxt;

    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign w_accept       = bus.load & r_ready;
    assign w_nonempty     = (r_count != '0);
    assign w_count_nxt    = r_count + c_CW'(w_accept) - c_CW'(w_pop);
    assign w_end_seen_nxt = r_end_seen | (w_accept & bus.pi_end);
    assign w_head_data    = r_mem_data[r_rd_ptr];
    assign w_head_ctl     = r_mem_ctl[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_data[r_wr_ptr] <= bus.pi_data;
            r_mem_ctl[r_wr_ptr]  <= {bus.pi_end, bus.pi_msb, bus.pi_low, bus.pi_fill, bus.pi_length};
        end
    end

    // Frame value occupies bits [L-1:0] of the frame register
    always_comb begin
        w_flen = 6'(4 * UNIT);
        case (w_head_ctl[1:0])
            2'd0:    w_flen = 6'(UNIT);
            2'd1:    w_flen = 6'(2 * UNIT);
            2'd2:    w_flen = 6'(3 * UNIT);
            default: w_flen = 6'(4 * UNIT);
        endcase
        w_ext = c_FW'(w_head_data);
        if (w_flen < c_DW6)
            w_frame = w_head_ctl[3] ? (w_ext & (c_ONES >> (c_FW6 - w_flen)))
                                    : (w_ext >> (c_DW6 - w_flen));
        else if (w_flen == c_DW6)
            w_frame = w_ext;
        else
            w_frame = w_head_ctl[2] ? (w_ext << (w_flen - c_DW6)) : w_ext;
    end

    assign w_idx       = r_msb ? (r_flen - 6'd1 - r_cnt) : r_cnt;
    assign w_bit_frame = |(r_frame & (c_ONE << w_idx));

`ifdef STI_PARITY_EN
    logic r_par;
    always_ff @(posedge clk) begin
        if (!reset)     r_par <= 1'b0;
        else if (w_pop) r_par <= ^w_frame;
    end
    assign w_final_cnt = r_flen;
    assign w_bit       = (r_cnt == r_flen) ? r_par : w_bit_frame;
`else
    assign w_final_cnt = r_flen - 6'd1;
    assign w_bit       = w_bit_frame;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_shift     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == w_final_cnt) begin
                    w_last = 1'b1;
                    // Chain straight into the next frame when one is waiting
                    if (w_nonempty) w_pop       = 1'b1;
                    else            w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_end_seen  <= 1'b0;
            r_ready     <= 1'b1;
            r_frame     <= '0;
            r_flen      <= '0;
            r_cnt       <= '0;
            r_msb       <= 1'b0;
            r_cur_end   <= 1'b0;
            r_so_data   <= 1'b0;
            r_so_valid  <= 1'b0;
            r_so_last   <= 1'b0;
            r_done_pend <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop) begin
                r_rd_ptr  <= ptr_inc(r_rd_ptr);
                r_frame   <= w_frame;
                r_flen    <= w_flen;
                r_msb     <= w_head_ctl[4];
                r_cur_end <= w_head_ctl[5];
                r_cnt     <= '0;
            end else if (w_shift) begin
                r_cnt <= r_cnt + 6'd1;
            end
            r_count     <= w_count_nxt;
            r_end_seen  <= w_end_seen_nxt;
            r_ready     <= (w_count_nxt < c_DEPTH) && !w_end_seen_nxt;
            r_so_valid  <= w_shift;
            r_so_last   <= w_last;
            r_so_data   <= w_shift & w_bit;
            r_done_pend <= w_last & r_cur_end;
            r_done      <= r_done | r_done_pend;
            r_ovf       <= r_ovf | (bus.load & ~r_ready);
        end
    end

    assign bus.pi_ready = r_ready;
    assign bus.so_data  = r_so_data;
    assign bus.so_valid = r_so_valid;
    assign bus.so_last  = r_so_last;
    assign bus.done     = r_done;
    assign bus.ovf_err  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sti_serializer_p.sv
//==============================================================================
// Module   : tb_sti_serializer_p
// Brief    : Self-checking bench for sti_serializer_p against a frame-level model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sti_serializer_p;
    localparam int DATA_W     = 16;
    localparam int UNIT       = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int NEVER      = 1 << 30;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sti_serializer_p_if #(.DATA_W(DATA_W)) bus ();

    sti_serializer_p #(
        .DATA_W     (DATA_W),
        .UNIT       (UNIT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level model: each accepted word becomes a scheduled run of bits
    int acc_e[$];
    int pop_e[$];
    bit exp_v[int];
    bit exp_d[int];
    bit exp_l[int];
    int prev_end, done_edge, ovf_edge, end_edge;
    bit end_seen;

    int n_cmp = 0;
    int n_bad = 0;

    longint unsigned cap_val = 0;
    int cap_n = 0;
    int cap_lasts = 0;

    int lit_seq = 0;
    int lit_ack = 0;
    string lit_name;
    longint unsigned lit_exp;
    int lit_n, lit_lasts, base_n, base_l;

    function automatic bit model_ready(int k);
        int c = 0;
        foreach (acc_e[i]) if (acc_e[i] <= k) c++;
        foreach (pop_e[i]) if (pop_e[i] <= k) c--;
        return (c < FIFO_DEPTH) && !(end_seen && end_edge <= k);
    endfunction

    function automatic void model_reset();
        acc_e.delete();
        pop_e.delete();
        exp_v.delete();
        exp_d.delete();
        exp_l.delete();
        prev_end  = -10;
        done_edge = NEVER;
        ovf_edge  = NEVER;
        end_edge  = 0;
        end_seen  = 1'b0;
    endfunction

    function automatic void model_load(int e, logic [15:0] d, logic [1:0] len,
                                       bit fill, bit msb, bit low, bit en);
        int L;
        int st;
        longint unsigned v;
        bit bits[$];
        bit p;
        L = UNIT * (int'(len) + 1);
        if (!model_ready(e - 1)) begin
            if (ovf_edge == NEVER) ovf_edge = e;
            return;
        end
        v = 64'(d);
        if (L < DATA_W)       v = low ? (v & ((64'd1 << L) - 64'd1)) : (v >> (DATA_W - L));
        else if (L > DATA_W)  v = fill ? (v << (L - DATA_W)) : v;
        for (int i = 0; i < L; i++) bits.push_back(msb ? v[L-1-i] : v[i]);
        p = 1'b0;
        foreach (bits[i]) p ^= bits[i];
`ifdef STI_PARITY_EN
        bits.push_back(p);
`endif
        st = (e + 2 > prev_end + 1) ? e + 2 : prev_end + 1;
        acc_e.push_back(e);
        pop_e.push_back(st - 1);
        foreach (bits[i]) begin
            exp_v[st+i] = 1'b1;
            exp_d[st+i] = bits[i];
            exp_l[st+i] = (i == bits.size() - 1);
        end
        prev_end = st + bits.size() - 1;
        if (en) begin
            end_seen  = 1'b1;
            end_edge  = e;
            done_edge = prev_end + 1;
        end
    endfunction

    function automatic void chk(string name, longint unsigned got, longint unsigned expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, expv);
        end
    endfunction

    // Single compare process: per-cycle model check, capture, literal checks
    always @(negedge clk) begin
        bit ev, ed, el;
        longint unsigned mask;
        ev = exp_v.exists(cyc) ? exp_v[cyc] : 1'b0;
        ed = exp_d.exists(cyc) ? exp_d[cyc] : 1'b0;
        el = exp_l.exists(cyc) ? exp_l[cyc] : 1'b0;
        chk("so_valid", 64'(bus.so_valid), 64'(ev));
        chk("so_data",  64'(bus.so_data),  64'(ed));
        chk("so_last",  64'(bus.so_last),  64'(el));
        chk("pi_ready", 64'(bus.pi_ready), 64'(model_ready(cyc)));
        chk("done",     64'(bus.done),     64'(cyc >= done_edge));
        chk("ovf_err",  64'(bus.ovf_err),  64'(cyc >= ovf_edge));
        if (bus.so_valid === 1'b1) begin
            cap_val = {cap_val[62:0], bus.so_data};
            cap_n++;
            if (bus.so_last === 1'b1) cap_lasts++;
        end
        if (lit_seq != lit_ack) begin
            lit_ack = lit_seq;
            mask = (64'd1 << lit_n) - 64'd1;
            chk({lit_name, "_bits"},  cap_val & mask, lit_exp);
            chk({lit_name, "_count"}, 64'(cap_n - base_n), 64'(lit_n));
            chk({lit_name, "_lasts"}, 64'(cap_lasts - base_l), 64'(lit_lasts));
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_load(logic [15:0] d, logic [1:0] len, bit fill, bit msb, bit low, bit en);
        bus.load      = 1'b1;
        bus.pi_data   = d;
        bus.pi_length = len;
        bus.pi_fill   = fill;
        bus.pi_msb    = msb;
        bus.pi_low    = low;
        bus.pi_end    = en;
        model_load(cyc + 1, d, len, fill, msb, low, en);
        tick();
        bus.load   = 1'b0;
        bus.pi_end = 1'b0;
    endtask

    task automatic mark();
        base_n = cap_n;
        base_l = cap_lasts;
    endtask

    task automatic lit(string name, longint unsigned expv, int n, int lasts);
        lit_name  = name;
        lit_exp   = expv;
        lit_n     = n;
        lit_lasts = lasts;
        lit_seq++;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        bus.load = 1'b0; bus.pi_data = '0; bus.pi_length = '0; bus.pi_fill = 1'b0;
        bus.pi_msb = 1'b0; bus.pi_low = 1'b0; bus.pi_end = 1'b0;
        reset = 1'b0;
        model_reset();
        tick(3);
        reset = 1'b1;
        tick(2);

        mark(); do_load(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0); tick(12);
        lit("t1_low", 64'hC3, 8, 1);
        mark(); do_load(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick(12);
        lit("t1_high", 64'hA5, 8, 1);

        mark(); do_load(16'h0001, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0); tick(20);
        lit("t2_lsb_first", 64'h8000, 16, 1);

        mark(); do_load(16'hFFFF, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0); tick(36);
        lit("t3_fill_hi", 64'hFFFF0000, 32, 1);
        mark(); do_load(16'hFFFF, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0); tick(36);
        lit("t3_fill_lo", 64'h0000FFFF, 32, 1);

        mark();
        do_load(16'h1111, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        do_load(16'h2222, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        do_load(16'h3333, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        do_load(16'h4444, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(30);
        lit("t4_b2b", 64'h112233, 24, 3);

        mark(); do_load(16'h00FF, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1); tick(12);
        lit("t5_end", 64'hFF, 8, 1);
        do_load(16'h1234, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0); tick(5);

        do_reset(); tick();
        do_load(16'hFFFF, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(6);
        do_reset(); tick(3);
        mark(); do_load(16'h00A5, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0); tick(12);
        lit("t6_after_rst", 64'hA5, 8, 1);

        mark(); do_load(16'h0007, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0); tick(14);
`ifdef STI_PARITY_EN
        lit("t7_parity", 64'h00F, 9, 1);
`else
        lit("t7_plain", 64'h07, 8, 1);
`endif
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
